score_arbiter: RTL and testbench

SCORE_ARBITER -- requirements
Module: score_arbiter

---
 rtl/score_arbiter_pkg.sv | 13 +
 rtl/score_arbiter_rr.sv | 28 ++
 rtl/score_arbiter.sv | 143 ++++++++++++++
 tb/tb_score_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_arbiter_pkg.sv
// Shared types and constants for the score arbiter: play state, score width
// and the default saturation ceiling.
package score_arbiter_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam int unsigned SCORE_W           = 20;
    localparam int unsigned DEFAULT_MAX_SCORE = 999999;

endpackage

// File: rtl/score_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping around, returned as a one-hot grant.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (32'(ptr) + k) % N;
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_arbiter.sv
// Score keeper: round-robin point awards, saturating score, high-score latch
// at game end and periodic score/high-score alternation while OVER.
module score_arbiter
    import score_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned PTS_W      = 12,
    parameter int unsigned MAX_SCORE  = DEFAULT_MAX_SCORE,
    parameter int unsigned ALT_PERIOD = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*PTS_W-1:0] pts,
    output logic [N_REQ-1:0]       ack,
    input  logic                   game_over,
    input  logic                   new_game,
    output logic [SCORE_W-1:0]     score,
    output logic [SCORE_W-1:0]     hi_score,
    output logic [SCORE_W-1:0]     sauce,
    output logic                   show_hi,
    output logic                   playing
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (ALT_PERIOD > 1) ? $clog2(ALT_PERIOD) : 1;
    localparam int unsigned SUM_W = SCORE_W + 1;

    state_t             r_state, w_state_n;
    logic [SCORE_W-1:0] r_score, w_score_n;
    logic [SCORE_W-1:0] r_hi, w_hi_n;
    logic [SCORE_W-1:0] r_sauce, w_sauce_n;
    logic               r_show, w_show_n;
    logic [N_REQ-1:0]   r_ack;
    logic [PTR_W-1:0]   r_ptr, w_ptr_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;

    logic               w_grant_en;
    logic [N_REQ-1:0]   w_req_avail;
    logic [N_REQ-1:0]   w_grant;
    logic [PTR_W-1:0]   w_sel_idx;
    logic [PTS_W-1:0]   w_pts_sel;
    logic [SUM_W-1:0]   w_sum;
    logic [SCORE_W-1:0] w_add_sat;

    // A requester whose ack is high this cycle is held off so a still-high
    // req is seen as a fresh request one cycle later.
    always_comb begin
        w_grant_en  = !new_game && ((r_state == OVER) || !game_over);
        w_req_avail = w_grant_en ? (req & ~r_ack) : '0;
    end

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (w_req_avail),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    always_comb begin
        w_sel_idx = '0;
        w_pts_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_idx = PTR_W'(i);
                w_pts_sel = pts[i*PTS_W +: PTS_W];
            end
        end
        w_sum     = {1'b0, r_score} + SUM_W'(w_pts_sel);
        w_add_sat = (w_sum > SUM_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                : w_sum[SCORE_W-1:0];
    end

    always_comb begin
        w_state_n = r_state;
        w_score_n = r_score;
        w_hi_n    = r_hi;
        w_show_n  = r_show;
        w_cnt_n   = r_cnt;
        w_ptr_n   = r_ptr;

        if (|w_grant) begin
            w_ptr_n = (w_sel_idx == PTR_W'(N_REQ - 1)) ? '0 : w_sel_idx + PTR_W'(1);
        end

        if (new_game) begin
            w_state_n = PLAY;
            w_score_n = '0;
            w_show_n  = 1'b0;
            w_cnt_n   = '0;
        end else if (r_state == PLAY) begin
            if (game_over) begin
                w_state_n = OVER;
                w_hi_n    = (r_score > r_hi) ? r_score : r_hi;
                w_show_n  = 1'b0;
                w_cnt_n   = '0;
            end else if (|w_grant) begin
                w_score_n = w_add_sat;
            end
        end else begin
            if (r_cnt == CNT_W'(ALT_PERIOD - 1)) begin
                w_cnt_n  = '0;
                w_show_n = ~r_show;
            end else begin
                w_cnt_n = r_cnt + CNT_W'(1);
            end
        end

        w_sauce_n = ((w_state_n == OVER) && w_show_n) ? w_hi_n : w_score_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OVER;
            r_score <= '0;
            r_hi    <= '0;
            r_sauce <= '0;
            r_show  <= 1'b0;
            r_ack   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_score <= w_score_n;
            r_hi    <= w_hi_n;
            r_sauce <= w_sauce_n;
            r_show  <= w_show_n;
            r_ack   <= w_grant;
            r_ptr   <= w_ptr_n;
            r_cnt   <= w_cnt_n;
        end
    end

    assign ack      = r_ack;
    assign score    = r_score;
    assign hi_score = r_hi;
    assign sauce    = r_sauce;
    assign show_hi  = r_show;
    assign playing  = (r_state == PLAY);

endmodule

// File: tb/tb_score_arbiter.sv
// Self-checking bench for score_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_score_arbiter;

    localparam int N     = 4;
    localparam int PTS_W = 12;
    localparam int MAXS  = 999999;
    localparam int ALT   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*PTS_W-1:0] pts = '0;
    logic [N-1:0]     ack;
    logic             game_over = 1'b0;
    logic             new_game = 1'b0;
    logic [19:0]      score, hi_score, sauce;
    logic             show_hi, playing;

    score_arbiter #(
        .N_REQ      (N),
        .PTS_W      (PTS_W),
        .MAX_SCORE  (MAXS),
        .ALT_PERIOD (ALT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .pts       (pts),
        .ack       (ack),
        .game_over (game_over),
        .new_game  (new_game),
        .score     (score),
        .hi_score  (hi_score),
        .sauce     (sauce),
        .show_hi   (show_hi),
        .playing   (playing)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: play flag, score totals, rotating pointer, and the
    // number of cycles spent in OVER (display phase derived by division).
    bit          m_play;
    int unsigned m_score, m_hi, m_over;
    int          m_ptr;
    bit [N-1:0]  m_ack;

    task automatic model_reset();
        m_play = 0; m_score = 0; m_hi = 0; m_over = 0; m_ptr = 0; m_ack = '0;
    endtask

    function automatic bit exp_show();
        return !m_play && (((m_over / ALT) % 2) == 1);
    endfunction

    function automatic int unsigned exp_sauce();
        return exp_show() ? m_hi : m_score;
    endfunction

    task automatic model_step();
        int          g;
        bit          en;
        int unsigned sum;
        bit [N-1:0]  one;
        g   = -1;
        one = 1;
        en  = !new_game && (!m_play || !game_over);
        if (en) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && req[idx] && !m_ack[idx]) g = idx;
            end
        end
        m_ack = (g >= 0) ? (one << g) : '0;
        if (g >= 0) m_ptr = (g + 1) % N;
        if (new_game) begin
            m_play = 1; m_score = 0; m_over = 0;
        end else if (m_play) begin
            if (game_over) begin
                if (m_score > m_hi) m_hi = m_score;
                m_play = 0; m_over = 0;
            end else if (g >= 0) begin
                sum = m_score + int'(pts[g*PTS_W +: PTS_W]);
                m_score = (sum > MAXS) ? MAXS : sum;
            end
        end else begin
            m_over++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_pts(input int i, input int v);
        pts[i*PTS_W +: PTS_W] = PTS_W'(v);
    endtask

    task automatic award(input int i, input int v);
        req = '0; req[i] = 1'b1;
        set_pts(i, v);
        tick();
        req = '0;
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #1;
        rst = 1'b1;
        #2;
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_tests++; if (score !== 20'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_tests++; if (hi_score !== 20'd0) begin n_fail++; $display("FAIL reset_hi: got %0d expected 0", hi_score); end
        n_tests++; if (sauce !== 20'd0) begin n_fail++; $display("FAIL reset_sauce: got %0d expected 0", sauce); end
        n_tests++; if (show_hi !== 1'b0) begin n_fail++; $display("FAIL reset_show_hi: got %b expected 0", show_hi); end
        n_tests++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing: got %b expected 0", playing); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_grant();
        new_game = 1'b1; tick(); new_game = 1'b0;
        req = 4'b0001; set_pts(0, 100);
        tick();
        req = '0;
        n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL first_ack: got %b expected 0001", ack); end
        n_tests++; if (score !== 20'd100) begin n_fail++; $display("FAIL first_score: got %0d expected 100", score); end
        n_tests++; if (sauce !== 20'd100) begin n_fail++; $display("FAIL first_sauce: got %0d expected 100", sauce); end
        n_tests++; if (playing !== 1'b1) begin n_fail++; $display("FAIL first_playing: got %b expected 1", playing); end
        tick();
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL first_ack_clear: got %b expected 0000", ack); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_ack, prev_exp;
        pulse_reset();
        new_game = 1'b1; tick(); new_game = 1'b0;
        req = '1;
        for (int i = 0; i < N; i++) set_pts(i, 1);
        prev_exp = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_ack = 4'b0001 << (k % 4);
            n_tests++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, ack, exp_ack); end
            n_tests++; if (ack === prev_exp) begin n_fail++; $display("FAIL rr_repeat[%0d]: got %b expected not %b", k, ack, prev_exp); end
            n_tests++; if (score !== 20'(k + 1)) begin n_fail++; $display("FAIL rr_score[%0d]: got %0d expected %0d", k, score, k + 1); end
            prev_exp = exp_ack;
        end
        req = '0;
        tick();
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_ack: got %b expected 0000", ack); end
        n_tests++; if (score !== 20'd8) begin n_fail++; $display("FAIL rr_total: got %0d expected 8", score); end
    endtask

    task automatic test_pts_zero();
        req = 4'b0010; set_pts(1, 0);
        tick();
        req = '0;
        n_tests++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL zero_ack: got %b expected 0010", ack); end
        n_tests++; if (score !== 20'd8) begin n_fail++; $display("FAIL zero_score: got %0d expected 8", score); end
        tick();
    endtask

    task automatic test_saturation();
        int sc;
        int v;
        new_game = 1'b1; tick(); new_game = 1'b0;
        sc = 0;
        while (sc < 999990) begin
            v = (999990 - sc > 4095) ? 4095 : 999990 - sc;
            award(0, v);
            sc += v;
        end
        n_tests++; if (score !== 20'd999990) begin n_fail++; $display("FAIL sat_setup: got %0d expected 999990", score); end
        req = 4'b0001; set_pts(0, 4095);
        tick();
        req = '0;
        n_tests++; if (score !== 20'd999999) begin n_fail++; $display("FAIL sat_clip: got %0d expected 999999", score); end
        tick();
        req = 4'b0001;
        tick();
        req = '0;
        n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL sat_hold_ack: got %b expected 0001", ack); end
        n_tests++; if (score !== 20'd999999) begin n_fail++; $display("FAIL sat_hold: got %0d expected 999999", score); end
        tick();
    endtask

    task automatic test_game_over();
        bit es;
        new_game = 1'b1; tick(); new_game = 1'b0;
        award(0, 300);
        game_over = 1'b1; tick(); game_over = 1'b0;
        n_tests++; if (hi_score !== 20'd300) begin n_fail++; $display("FAIL go_hi300: got %0d expected 300", hi_score); end
        n_tests++; if (playing !== 1'b0) begin n_fail++; $display("FAIL go_playing: got %b expected 0", playing); end
        new_game = 1'b1; tick(); new_game = 1'b0;
        award(0, 500);
        game_over = 1'b1; tick(); game_over = 1'b0;
        n_tests++; if (hi_score !== 20'd500) begin n_fail++; $display("FAIL go_hi500: got %0d expected 500", hi_score); end
        n_tests++; if (sauce !== 20'd500) begin n_fail++; $display("FAIL go_sauce: got %0d expected 500", sauce); end
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) game_over = 1'b1;
            tick();
            game_over = 1'b0;
            es = ((k / 4) % 2) == 1;
            n_tests++; if (show_hi !== es) begin n_fail++; $display("FAIL alt500_show[%0d]: got %b expected %b", k, show_hi, es); end
            n_tests++; if (sauce !== 20'd500) begin n_fail++; $display("FAIL alt500_sauce[%0d]: got %0d expected 500", k, sauce); end
        end
        n_tests++; if (hi_score !== 20'd500) begin n_fail++; $display("FAIL go_ignored_hi: got %0d expected 500", hi_score); end
        new_game = 1'b1; tick(); new_game = 1'b0;
        award(0, 200);
        game_over = 1'b1; tick(); game_over = 1'b0;
        n_tests++; if (hi_score !== 20'd500) begin n_fail++; $display("FAIL go_hi_keep: got %0d expected 500", hi_score); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            es = ((k / 4) % 2) == 1;
            n_tests++; if (show_hi !== es) begin n_fail++; $display("FAIL alt200_show[%0d]: got %b expected %b", k, show_hi, es); end
            n_tests++; if (sauce !== (es ? 20'd500 : 20'd200)) begin n_fail++; $display("FAIL alt200_sauce[%0d]: got %0d expected %0d", k, sauce, es ? 500 : 200); end
        end
    endtask

    task automatic test_simultaneous();
        req = 4'b0001; set_pts(0, 77);
        game_over = 1'b1; new_game = 1'b1;
        tick();
        game_over = 1'b0; new_game = 1'b0;
        n_tests++; if (playing !== 1'b1) begin n_fail++; $display("FAIL both_playing: got %b expected 1", playing); end
        n_tests++; if (score !== 20'd0) begin n_fail++; $display("FAIL both_score: got %0d expected 0", score); end
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL both_ack: got %b expected 0000", ack); end
        tick();
        req = '0;
        n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL both_next_ack: got %b expected 0001", ack); end
        n_tests++; if (score !== 20'd77) begin n_fail++; $display("FAIL both_next_score: got %0d expected 77", score); end
        tick();
        new_game = 1'b1; tick(); new_game = 1'b0;
        n_tests++; if (score !== 20'd0) begin n_fail++; $display("FAIL restart_score: got %0d expected 0", score); end
        n_tests++; if (playing !== 1'b1) begin n_fail++; $display("FAIL restart_playing: got %b expected 1", playing); end
    endtask

    task automatic test_rst_mid_ack();
        req = 4'b0001; set_pts(0, 50);
        tick();
        n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL rstack_pre: got %b expected 0001", ack); end
        rst = 1'b1;
        #1;
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rstack_ack: got %b expected 0000", ack); end
        n_tests++; if (score !== 20'd0) begin n_fail++; $display("FAIL rstack_score: got %0d expected 0", score); end
        n_tests++; if (hi_score !== 20'd0) begin n_fail++; $display("FAIL rstack_hi: got %0d expected 0", hi_score); end
        n_tests++; if (playing !== 1'b0) begin n_fail++; $display("FAIL rstack_playing: got %b expected 0", playing); end
        req = '0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int r;
        new_game = 1'b1; tick(); new_game = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && m_ack[i]) begin
                    if ($urandom_range(3) != 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    r = int'($urandom_range(9));
                    set_pts(i, (r == 0) ? 0 : (r == 1) ? 4095 : int'($urandom_range(4095)));
                end
            end
            game_over = ($urandom_range(24) == 0);
            new_game  = ($urandom_range(39) == 0);
            tick();
            n_tests++; if (ack !== m_ack) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b expected %b", cyc, ack, m_ack); end
            n_tests++; if (score !== 20'(m_score)) begin n_fail++; $display("FAIL rnd_score[%0d]: got %0d expected %0d", cyc, score, m_score); end
            n_tests++; if (hi_score !== 20'(m_hi)) begin n_fail++; $display("FAIL rnd_hi[%0d]: got %0d expected %0d", cyc, hi_score, m_hi); end
            n_tests++; if (show_hi !== exp_show()) begin n_fail++; $display("FAIL rnd_show[%0d]: got %b expected %b", cyc, show_hi, exp_show()); end
            n_tests++; if (sauce !== 20'(exp_sauce())) begin n_fail++; $display("FAIL rnd_sauce[%0d]: got %0d expected %0d", cyc, sauce, exp_sauce()); end
            n_tests++; if (playing !== m_play) begin n_fail++; $display("FAIL rnd_playing[%0d]: got %b expected %b", cyc, playing, m_play); end
        end
        game_over = 1'b0;
        new_game  = 1'b0;
        req       = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_grant();
        test_round_robin();
        test_pts_zero();
        test_saturation();
        test_game_over();
        test_simultaneous();
        test_rst_mid_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
